// File: rtl/rx_deframe.sv
// rx_deframe: receive-path deframer for the Ethernet sample link.
// Checks preamble/SFD, EtherType and FCS; packs payload into 40-bit FIFO words.
// Ports: clk125/rstn clock and async active-low reset; rx_dv/rx_er/rx_byte
// byte stream from the RGMII capture; afull FIFO almost-full; wdata/wren
// FIFO write; frame_ok/frame_bad status pulses; ok_cnt/bad_cnt counters.
module rx_deframe #(
  parameter logic [15:0] ETHTYPE   = 16'h88B5,
  parameter int          MAX_WORDS = 300
) (
  input  logic        clk125,
  input  logic        rstn,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rx_byte,
  input  logic        afull,
  output logic [39:0] wdata,
  output logic        wren,
  output logic        frame_ok,
  output logic        frame_bad,
  output logic [15:0] ok_cnt,
  output logic [15:0] bad_cnt
);

  localparam int            WW      = $clog2(MAX_WORDS + 1);
  localparam logic [WW-1:0] MAXW    = WW'(MAX_WORDS);
  localparam logic [WW-1:0] ONE     = WW'(1);
  localparam logic [31:0]   POLY    = 32'hEDB88320;
  localparam logic [31:0]   RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    IDLE, PRE, HDR, PAY, DROP
  } state_t;

  state_t          state;
  logic [31:0]     crc;
  logic [3:0]      hcnt;
  logic [3:0][7:0] dly;
  logic [2:0]      dcnt;
  logic [31:0]     pk;
  logic [2:0]      pcnt;
  logic [WW-1:0]   wcnt;
  logic            bad;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] crc_nx;
  logic        eth_hit;
  logic [39:0] word;
  logic        eof_bad;

  assign crc_nx  = crc_step(crc, rx_byte);
  assign eth_hit = (hcnt == 4'd12)
                 ? (rx_byte == ETHTYPE[15:8])
                 : (rx_byte == ETHTYPE[7:0]);
  // dly[3] is the oldest byte; it completes the word held in pk
  assign word    = {pk, dly[3]};
  // dcnt < 4 means the FCS itself was short (runt)
  assign eof_bad = bad
                 | (crc != RESIDUE)
                 | (dcnt != 3'd4)
                 | (pcnt != 3'd0);

  always_ff @(posedge clk125 or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      crc       <= '0;
      hcnt      <= '0;
      dly       <= '0;
      dcnt      <= '0;
      pk        <= '0;
      pcnt      <= '0;
      wcnt      <= '0;
      bad       <= 1'b0;
      wdata     <= '0;
      wren      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_bad <= 1'b0;
      ok_cnt    <= '0;
      bad_cnt   <= '0;
    end else begin
      wren      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_bad <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_dv)
            state <= (rx_byte == 8'h55) ? PRE : DROP;
        end
        PRE: begin
          if (!rx_dv) begin
            state <= IDLE;
          end else if (rx_er) begin
            bad   <= 1'b1;
            state <= DROP;
          end else if (rx_byte == 8'hD5) begin
            state <= HDR;
            crc   <= '1;
            hcnt  <= '0;
            dcnt  <= '0;
            pcnt  <= '0;
            wcnt  <= '0;
            bad   <= 1'b0;
          end else if (rx_byte != 8'h55) begin
            state <= DROP;
          end
        end
        HDR: begin
          if (!rx_dv) begin
            // truncated inside the header
            frame_bad <= 1'b1;
            bad_cnt   <= sat_inc(bad_cnt);
            state     <= IDLE;
          end else if (rx_er) begin
            bad   <= 1'b1;
            state <= DROP;
          end else begin
            crc  <= crc_nx;
            hcnt <= hcnt + 4'd1;
            if (hcnt >= 4'd12 && !eth_hit)
              state <= DROP;
            else if (hcnt == 4'd13)
              state <= PAY;
          end
        end
        PAY: begin
          if (!rx_dv) begin
            if (eof_bad) begin
              frame_bad <= 1'b1;
              bad_cnt   <= sat_inc(bad_cnt);
            end else begin
              frame_ok <= 1'b1;
              ok_cnt   <= sat_inc(ok_cnt);
            end
            bad   <= 1'b0;
            state <= IDLE;
          end else if (rx_er) begin
            bad   <= 1'b1;
            state <= DROP;
          end else begin
            crc <= crc_nx;
            dly <= {dly[2:0], rx_byte};
            if (dcnt != 3'd4) begin
              dcnt <= dcnt + 3'd1;
            end else if (pcnt != 3'd4) begin
              pk   <= {pk[23:0], dly[3]};
              pcnt <= pcnt + 3'd1;
            end else begin
              pcnt <= '0;
              if (wcnt == MAXW) begin
                bad   <= 1'b1;
                state <= DROP;
              end else begin
                wcnt <= wcnt + ONE;
                // a blocked word still counts against the frame
                if (afull) begin
                  bad <= 1'b1;
                end else begin
                  wren  <= 1'b1;
                  wdata <= word;
                end
              end
            end
          end
        end
        DROP: begin
          if (!rx_dv) begin
            if (bad) begin
              frame_bad <= 1'b1;
              bad_cnt   <= sat_inc(bad_cnt);
            end
            bad   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_deframe.sv
// tb_rx_deframe: directed bench for rx_deframe.
// Builds frames with a locally computed FCS and checks words and pulses.
module tb_rx_deframe;

  logic        clk125 = 1'b0;
  logic        rstn   = 1'b0;
  logic        rx_dv  = 1'b0;
  logic        rx_er  = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        afull  = 1'b0;
  logic [39:0] wdata;
  logic        wren;
  logic        frame_ok;
  logic        frame_bad;
  logic [15:0] ok_cnt;
  logic [15:0] bad_cnt;

  rx_deframe dut (
    .clk125    (clk125),
    .rstn      (rstn),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .rx_byte   (rx_byte),
    .afull     (afull),
    .wdata     (wdata),
    .wren      (wren),
    .frame_ok  (frame_ok),
    .frame_bad (frame_bad),
    .ok_cnt    (ok_cnt),
    .bad_cnt   (bad_cnt)
  );

  always #4 clk125 = ~clk125;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int t0     = 0;
  int t_end  = 0;
  int both   = 0;

  logic [7:0]  fr[$];
  logic [39:0] wq[$];
  int          wcq[$];
  int          okq[$];
  int          badq[$];

  always @(posedge clk125) cyc <= cyc + 1;

  always @(negedge clk125) begin
    if (wren) begin
      wq.push_back(wdata);
      wcq.push_back(cyc);
    end
    if (frame_ok) okq.push_back(cyc);
    if (frame_bad) badq.push_back(cyc);
    if (frame_ok && frame_bad) both++;
  end

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] w_at(input int i);
    return (i < wq.size()) ? 64'(wq[i]) : 64'hx;
  endfunction

  function automatic logic [63:0] wc_at(input int i);
    return (i < wcq.size()) ? 64'(wcq[i]) : 64'hx;
  endfunction

  function automatic logic [63:0] ok_at(input int i);
    return (i < okq.size()) ? 64'(okq[i]) : 64'hx;
  endfunction

  function automatic logic [63:0] bad_at(input int i);
    return (i < badq.size()) ? 64'(badq[i]) : 64'hx;
  endfunction

  function automatic logic [31:0] crc32(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(
    input logic [15:0] eth,
    input int          npay,
    input bit          flip
  );
    logic [31:0] c;
    logic [31:0] fcs;
    fr.delete();
    for (int i = 0; i < 7; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 5; i++) fr.push_back(8'h02 * 8'(i == 0));
    fr.push_back(8'h01);
    for (int i = 0; i < 5; i++) fr.push_back(8'h02 * 8'(i == 0));
    fr.push_back(8'h02);
    fr.push_back(eth[15:8]);
    fr.push_back(eth[7:0]);
    for (int i = 0; i < npay; i++) fr.push_back(8'(i));
    c = 32'hFFFFFFFF;
    for (int i = 8; i < fr.size(); i++) c = crc32(c, fr[i]);
    fcs = ~c;
    fr.push_back(fcs[7:0]);
    fr.push_back(fcs[15:8]);
    fr.push_back(fcs[23:16]);
    fr.push_back(fcs[31:24] ^ (flip ? 8'h01 : 8'h00));
  endtask

  task automatic clr();
    wq.delete();
    wcq.delete();
    okq.delete();
    badq.delete();
  endtask

  task automatic send(
    input int afull_from,
    input int er_at,
    input int rst_at,
    input int gap
  );
    for (int k = 0; k < fr.size(); k++) begin
      @(negedge clk125);
      if (k == rst_at) begin
        rstn = 1'b0;
        #1;
        chk("rst_mid_wren", 64'(wren), 64'd0);
        chk("rst_mid_okcnt", 64'(ok_cnt), 64'd0);
        chk("rst_mid_badcnt", 64'(bad_cnt), 64'd0);
        #1;
        rstn = 1'b1;
      end
      if (k == 0) t0 = cyc;
      rx_dv   = 1'b1;
      rx_byte = fr[k];
      afull   = (afull_from >= 0) && (k >= afull_from);
      rx_er   = (k == er_at);
    end
    @(negedge clk125);
    t_end   = cyc;
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    afull   = 1'b0;
    rx_byte = 8'h00;
    repeat (gap - 1) @(negedge clk125);
  endtask

  initial begin
    repeat (3) @(negedge clk125);
    chk("reset_wren", 64'(wren), 64'd0);
    chk("reset_wdata", 64'(wdata), 64'd0);
    chk("reset_ok", 64'(frame_ok), 64'd0);
    chk("reset_bad", 64'(frame_bad), 64'd0);
    chk("reset_okcnt", 64'(ok_cnt), 64'd0);
    chk("reset_badcnt", 64'(bad_cnt), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk125);

    // good frame, 10 payload bytes
    clr();
    build(16'h88B5, 10, 1'b0);
    send(-1, -1, -1, 6);
    chk("good_nw", 64'(wq.size()), 64'd2);
    chk("good_w0", w_at(0), 64'h0001020304);
    chk("good_w1", w_at(1), 64'h0506070809);
    chk("good_lat", wc_at(0), 64'(t0 + 31));
    chk("good_gap", wc_at(1) - wc_at(0), 64'd5);
    chk("good_nok", 64'(okq.size()), 64'd1);
    chk("good_okcyc", ok_at(0), 64'(t_end + 1));
    chk("good_nbad", 64'(badq.size()), 64'd0);
    chk("good_okcnt", 64'(ok_cnt), 64'd1);
    chk("good_badcnt", 64'(bad_cnt), 64'd0);

    // FCS bit flipped
    clr();
    build(16'h88B5, 10, 1'b1);
    send(-1, -1, -1, 6);
    chk("fcs_nw", 64'(wq.size()), 64'd2);
    chk("fcs_w0", w_at(0), 64'h0001020304);
    chk("fcs_w1", w_at(1), 64'h0506070809);
    chk("fcs_nok", 64'(okq.size()), 64'd0);
    chk("fcs_nbad", 64'(badq.size()), 64'd1);
    chk("fcs_badcyc", bad_at(0), 64'(t_end + 1));
    chk("fcs_badcnt", 64'(bad_cnt), 64'd1);

    // foreign EtherType: silent
    clr();
    build(16'h0800, 10, 1'b0);
    send(-1, -1, -1, 6);
    chk("eth_nw", 64'(wq.size()), 64'd0);
    chk("eth_nok", 64'(okq.size()), 64'd0);
    chk("eth_nbad", 64'(badq.size()), 64'd0);
    chk("eth_okcnt", 64'(ok_cnt), 64'd1);
    chk("eth_badcnt", 64'(bad_cnt), 64'd1);

    // afull during second word
    clr();
    build(16'h88B5, 10, 1'b0);
    send(31, -1, -1, 6);
    chk("afull_nw", 64'(wq.size()), 64'd1);
    chk("afull_w0", w_at(0), 64'h0001020304);
    chk("afull_nok", 64'(okq.size()), 64'd0);
    chk("afull_nbad", 64'(badq.size()), 64'd1);
    chk("afull_badcnt", 64'(bad_cnt), 64'd2);

    // rx_er on payload byte 3
    clr();
    build(16'h88B5, 10, 1'b0);
    send(-1, 25, -1, 6);
    chk("er_nw", 64'(wq.size()), 64'd0);
    chk("er_nok", 64'(okq.size()), 64'd0);
    chk("er_nbad", 64'(badq.size()), 64'd1);
    chk("er_badcyc", bad_at(0), 64'(t_end + 1));
    chk("er_badcnt", 64'(bad_cnt), 64'd3);

    // 7-byte payload: partial word
    clr();
    build(16'h88B5, 7, 1'b0);
    send(-1, -1, -1, 6);
    chk("part_nw", 64'(wq.size()), 64'd1);
    chk("part_w0", w_at(0), 64'h0001020304);
    chk("part_nok", 64'(okq.size()), 64'd0);
    chk("part_nbad", 64'(badq.size()), 64'd1);
    chk("part_badcnt", 64'(bad_cnt), 64'd4);

    // reset mid-payload, then a good frame
    clr();
    build(16'h88B5, 10, 1'b0);
    send(-1, -1, 25, 6);
    chk("rst_nw", 64'(wq.size()), 64'd0);
    chk("rst_nok", 64'(okq.size()), 64'd0);
    chk("rst_nbad", 64'(badq.size()), 64'd0);
    clr();
    send(-1, -1, -1, 6);
    chk("rst2_nw", 64'(wq.size()), 64'd2);
    chk("rst2_nok", 64'(okq.size()), 64'd1);
    chk("rst2_okcnt", 64'(ok_cnt), 64'd1);
    chk("rst2_badcnt", 64'(bad_cnt), 64'd0);

    // two good frames with a 1-cycle gap
    clr();
    send(-1, -1, -1, 1);
    send(-1, -1, -1, 6);
    chk("b2b_nw", 64'(wq.size()), 64'd4);
    chk("b2b_nok", 64'(okq.size()), 64'd2);
    chk("b2b_space", ok_at(1) - ok_at(0), 64'(fr.size() + 1));
    chk("b2b_okcnt", 64'(ok_cnt), 64'd3);
    chk("never_both", 64'(both), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
